// File: rtl/mem_preload_launcher.sv
// Preload/launch front-end for the HLS `main` accelerator.
// Streams base-address and data-byte tokens into the accelerator RAM through
// slave channel 0. On end-of-vector it pulses start_port and counts cycles
// until done_port, then emits one result record.
module mem_preload_launcher #(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 16,
   parameter int CYC_W       = 32,
   parameter int MAX_CYCLES  = 200000000,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [31:0]       in_data,
   output logic [1:0]        S_oe_ram,
   output logic [1:0]        S_we_ram,
   output logic [ADDR_W-1:0] S_addr_ram,
   output logic [DATA_W-1:0] S_Wdata_ram,
   output logic [7:0]        S_data_ram_size,
   input  logic [1:0]        Sout_DataRdy,
   output logic              start_port,
   input  logic              done_port,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CYC_W-1:0]  res_cycles,
   output logic [1:0]        res_status
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [1:0] K_BASE = 2'd0;
   localparam logic [1:0] K_BYTE = 2'd1;
   localparam logic [1:0] K_END  = 2'd2;

   localparam logic [1:0] ST_OK     = 2'd0;
   localparam logic [1:0] ST_RUN_TO = 2'd1;
   localparam logic [1:0] ST_ACK_TO = 2'd2;

   localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);

   // DRAIN swallows the rest of a vector whose load failed on an ack timeout.
   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_START, S_RUN, S_REPORT, S_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] offset_q;
   logic [7:0]        byte_q;
   logic [ACK_W-1:0]  ack_cnt_q;
   logic [CYC_W-1:0]  cyc_q;
   logic [CYC_W-1:0]  res_cycles_q;
   logic [1:0]        res_status_q;

   logic              tok_fire;
   logic              ack;
   logic              ack_expire;
   logic [CYC_W-1:0]  cyc_now;
   logic              run_timeout;
   logic              unused_bits;

   // A token is taken whenever we are in a token-consuming state.
   assign tok_fire    = in_valid && ((state_q == S_IDLE) || (state_q == S_DRAIN));
   assign ack         = Sout_DataRdy[0];
   // The ack counter would reach ACK_TIMEOUT at the end of this cycle.
   assign ack_expire  = !ack && (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));
   // Cycle count including the current RUN cycle; saturates instead of wrapping.
   assign cyc_now     = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
   assign run_timeout = (cyc_now >= CYC_LIMIT);
   // Upper address bits and the channel-1 acknowledge have no function here.
   assign unused_bits = ^{in_data[31:ADDR_W], Sout_DataRdy[1]};

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (tok_fire) begin
               if (in_kind == K_BYTE) begin
                  state_d = S_WRITE;
               end else if (in_kind == K_END) begin
                  state_d = S_START;
               end
            end
         end
         S_WRITE: begin
            if (ack) begin
               state_d = S_IDLE;
            end else if (ack_expire) begin
               state_d = S_REPORT;
            end
         end
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (done_port || run_timeout) begin
               state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            if (res_ready) begin
               state_d = (res_status_q == ST_ACK_TO) ? S_DRAIN : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (tok_fire && (in_kind == K_END)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded purely from state so they drop with an asynchronous reset.
   always_comb begin
      in_ready        = 1'b0;
      S_oe_ram        = 2'b00;
      S_we_ram        = 2'b00;
      S_addr_ram      = '0;
      S_Wdata_ram     = '0;
      S_data_ram_size = 8'd0;
      start_port      = 1'b0;
      res_valid       = 1'b0;
      res_cycles      = '0;
      res_status      = ST_OK;
      case (state_q)
         S_IDLE, S_DRAIN: in_ready = !reset;
         S_WRITE: begin
            S_we_ram        = 2'b01;
            S_addr_ram      = base_q + offset_q;
            S_Wdata_ram     = {{(DATA_W - 8){1'b0}}, byte_q};
            S_data_ram_size = 8'd8;
         end
         S_START: start_port = 1'b1;
         S_REPORT: begin
            res_valid  = 1'b1;
            res_cycles = res_cycles_q;
            res_status = res_status_q;
         end
         default: ;
      endcase
   end

   // Address pointer, write byte, ack/cycle counters and the result record.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         base_q       <= '0;
         offset_q     <= '0;
         byte_q       <= 8'd0;
         ack_cnt_q    <= '0;
         cyc_q        <= '0;
         res_cycles_q <= '0;
         res_status_q <= ST_OK;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tok_fire && (in_kind == K_BASE)) begin
                  base_q   <= in_data[ADDR_W-1:0];
                  offset_q <= '0;
               end else if (tok_fire && (in_kind == K_BYTE)) begin
                  byte_q    <= in_data[7:0];
                  ack_cnt_q <= '0;
               end
            end
            S_WRITE: begin
               if (ack) begin
                  offset_q <= offset_q + 1'b1;
               end else begin
                  ack_cnt_q <= ack_cnt_q + 1'b1;
                  if (ack_expire) begin
                     res_cycles_q <= '0;
                     res_status_q <= ST_ACK_TO;
                  end
               end
            end
            S_START: cyc_q <= {{(CYC_W - 1){1'b0}}, 1'b1};
            S_RUN: begin
               if (done_port) begin
                  res_cycles_q <= cyc_now;
                  res_status_q <= ST_OK;
               end else if (run_timeout) begin
                  res_cycles_q <= CYC_LIMIT;
                  res_status_q <= ST_RUN_TO;
               end else begin
                  cyc_q <= cyc_now;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  base_q   <= '0;
                  offset_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_preload_launcher.sv
// Self-checking bench for mem_preload_launcher: a vector table drives the load
// phase, hand-written sequences cover runs, timeouts and reset. Expected writes
// and results go into queues when stimulus is driven and are popped by a sink
// process that also acknowledges writes and consumes result records.
module tb_mem_preload_launcher;

   localparam int ADDR_W  = 14;
   localparam int DATA_W  = 16;
   localparam int CYC_W   = 32;
   localparam int MAX_CYC = 20;
   localparam int ACK_TO  = 15;

   logic              clock = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [31:0]       in_data;
   logic [1:0]        S_oe_ram;
   logic [1:0]        S_we_ram;
   logic [ADDR_W-1:0] S_addr_ram;
   logic [DATA_W-1:0] S_Wdata_ram;
   logic [7:0]        S_data_ram_size;
   logic [1:0]        Sout_DataRdy;
   logic              start_port;
   logic              done_port;
   logic              res_valid;
   logic              res_ready;
   logic [CYC_W-1:0]  res_cycles;
   logic [1:0]        res_status;

   mem_preload_launcher #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W),
      .MAX_CYCLES(MAX_CYC), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_data(in_data),
      .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
      .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
      .Sout_DataRdy(Sout_DataRdy), .start_port(start_port), .done_port(done_port),
      .res_valid(res_valid), .res_ready(res_ready), .res_cycles(res_cycles),
      .res_status(res_status)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } wr_t;

   typedef struct {
      logic [CYC_W-1:0] cyc;
      logic [1:0]       st;
   } res_t;

   typedef struct {
      logic [1:0]        kind;
      logic [31:0]       data;
      int                lat;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } vec_t;

   wr_t  wr_q[$];
   res_t res_q[$];
   vec_t tab[11];

   int checks    = 0;
   int errors    = 0;
   int ack_lat   = 1;
   bit ack_en    = 1'b1;
   int res_hold  = 0;
   int we_cycles = 0;
   int start_cnt = 0;
   int we_age    = 0;
   int res_wait  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event within bound, expected one", name);
   endtask

   // Sink: acknowledges writes, consumes results, pops and compares scoreboards.
   initial begin
      wr_t  w;
      res_t r;
      Sout_DataRdy = 2'b00;
      res_ready    = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            Sout_DataRdy = 2'b00;
            res_ready    = 1'b0;
            we_age       = 0;
            res_wait     = 0;
            continue;
         end
         if (S_we_ram[0]) begin
            we_cycles++;
            if (ack_en && (we_age == ack_lat)) begin
               Sout_DataRdy = 2'b01;
               if (wr_q.size() == 0) begin
                  fail_bound("unexpected_write");
               end else begin
                  w = wr_q.pop_front();
                  chk("wr_addr", 64'(S_addr_ram), 64'(w.addr));
                  chk("wr_data", 64'(S_Wdata_ram), 64'(w.wdata));
                  chk("wr_size", 64'(S_data_ram_size), 64'd8);
                  chk("wr_oe_we", 64'({S_oe_ram, S_we_ram}), 64'h1);
                  $display("write addr=0x%04h data=0x%04h", S_addr_ram, S_Wdata_ram);
               end
            end else begin
               Sout_DataRdy = 2'b00;
            end
            we_age++;
         end else begin
            Sout_DataRdy = 2'b00;
            we_age       = 0;
         end
         if (start_port) start_cnt++;
         if (res_valid) begin
            if (res_q.size() == 0) begin
               fail_bound("unexpected_result");
               res_ready = 1'b1;
            end else begin
               r = res_q[0];
               chk("res_cycles", 64'(res_cycles), 64'(r.cyc));
               chk("res_status", 64'(res_status), 64'(r.st));
               if (res_wait >= res_hold) begin
                  res_ready = 1'b1;
                  void'(res_q.pop_front());
                  res_wait = 0;
                  $display("result cycles=%0d status=%0d", res_cycles, res_status);
               end else begin
                  res_ready = 1'b0;
                  res_wait++;
               end
            end
         end else begin
            res_ready = 1'b0;
            res_wait  = 0;
         end
      end
   end

   task automatic send_tok(input logic [1:0] k, input logic [31:0] d);
      int n = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_kind  = k;
      in_data  = d;
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) fail_bound("in_ready");
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_wr_drain();
      int n = 0;
      while (wr_q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (wr_q.size() != 0) begin
         fail_bound("write_ack");
         wr_q.delete();
      end
   endtask

   task automatic wait_res_drain();
      int n = 0;
      while (res_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (res_q.size() != 0) begin
         fail_bound("result");
         res_q.delete();
      end
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clock);
         if (start_port) ok = 1'b1;
      end
      if (!ok) fail_bound("start_port");
   endtask

   // One launch: done_dly is the distance from the start cycle to done (<0: never).
   task automatic do_run(input int done_dly, input logic [CYC_W-1:0] exp_cyc,
                         input logic [1:0] exp_st, input int hold);
      res_t r;
      bit   ok;
      int   s0;
      r.cyc    = exp_cyc;
      r.st     = exp_st;
      res_hold = hold;
      res_q.push_back(r);
      s0 = start_cnt;
      send_tok(2'd2, 32'd0);
      wait_start(ok);
      if (ok) begin
         @(negedge clock);
         chk("start_width", 64'(start_port), 64'd0);
         if (done_dly >= 2) begin
            repeat (done_dly - 1) @(negedge clock);
            done_port = 1'b1;
            @(negedge clock);
            done_port = 1'b0;
         end
      end
      wait_res_drain();
      chk("start_count", 64'(start_cnt - s0), 64'd1);
      res_hold = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected one");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_t w;
      bit  ok;
      int  w0;
      int  s0;

      tab[0]  = '{2'd0, 32'h0000_0100, 0,  1'b0, 14'h0000, 16'h0000};
      tab[1]  = '{2'd1, 32'h0000_00AA, 1,  1'b1, 14'h0100, 16'h00AA};
      tab[2]  = '{2'd1, 32'h0000_00BB, 1,  1'b1, 14'h0101, 16'h00BB};
      tab[3]  = '{2'd1, 32'h0000_00CC, 1,  1'b1, 14'h0102, 16'h00CC};
      tab[4]  = '{2'd3, 32'hDEAD_BEEF, 0,  1'b0, 14'h0000, 16'h0000};
      tab[5]  = '{2'd1, 32'h0000_01DD, 0,  1'b1, 14'h0103, 16'h00DD};
      tab[6]  = '{2'd0, 32'h0000_3FFF, 0,  1'b0, 14'h0000, 16'h0000};
      tab[7]  = '{2'd1, 32'h0000_0011, 3,  1'b1, 14'h3FFF, 16'h0011};
      tab[8]  = '{2'd1, 32'h0000_0022, 1,  1'b1, 14'h0000, 16'h0022};
      tab[9]  = '{2'd0, 32'hFFFF_C005, 0,  1'b0, 14'h0000, 16'h0000};
      tab[10] = '{2'd1, 32'h0000_0033, 14, 1'b1, 14'h0005, 16'h0033};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_kind   = 2'd0;
      in_data   = 32'd0;
      done_port = 1'b0;
      #1;
      chk("reset_bus", 64'({in_ready, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size}), 64'd0);
      chk("reset_ctl", 64'({start_port, res_valid, res_cycles, res_status}), 64'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_ready", 64'(in_ready), 64'd1);

      // Load phase from the vector table.
      for (int i = 0; i < 11; i++) begin
         ack_lat = tab[i].lat;
         if (tab[i].wr) begin
            w.addr  = tab[i].addr;
            w.wdata = tab[i].wdata;
            wr_q.push_back(w);
         end
         send_tok(tab[i].kind, tab[i].data);
         if (tab[i].wr) begin
            @(negedge clock);
            chk("write_not_ready", 64'(in_ready), 64'd0);
            wait_wr_drain();
         end
      end
      ack_lat = 1;

      // Runs: normal with held-off consumer, timeout, done on/just before timeout.
      do_run(9, 32'd10, 2'd0, 5);
      do_run(-1, 32'd20, 2'd1, 0);
      do_run(19, 32'd20, 2'd0, 0);
      do_run(18, 32'd19, 2'd0, 1);

      // Write never acknowledged: timeout result, then the vector is drained.
      ack_en = 1'b0;
      begin
         res_t r;
         r.cyc = 32'd0;
         r.st  = 2'd2;
         res_q.push_back(r);
      end
      w0 = we_cycles;
      send_tok(2'd1, 32'h0000_0077);
      wait_res_drain();
      chk("ack_timeout_cycles", 64'(we_cycles - w0), 64'd15);
      ack_en = 1'b1;
      s0 = start_cnt;
      w0 = we_cycles;
      send_tok(2'd1, 32'h0000_0088);
      send_tok(2'd0, 32'h0000_1234);
      send_tok(2'd1, 32'h0000_0099);
      send_tok(2'd2, 32'd0);
      repeat (3) @(negedge clock);
      chk("drain_no_write", 64'(we_cycles - w0), 64'd0);
      chk("drain_no_start", 64'(start_cnt - s0), 64'd0);
      chk("drain_idle", 64'(in_ready), 64'd1);
      w.addr  = 14'h0000;
      w.wdata = 16'h0044;
      wr_q.push_back(w);
      send_tok(2'd1, 32'h0000_0044);
      wait_wr_drain();

      // Reset during RUN: outputs drop at once, pointer cleared, no result.
      w.addr  = 14'h0200;
      w.wdata = 16'h0055;
      wr_q.push_back(w);
      send_tok(2'd0, 32'h0000_0200);
      send_tok(2'd1, 32'h0000_0055);
      wait_wr_drain();
      send_tok(2'd2, 32'd0);
      wait_start(ok);
      repeat (3) @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_run_bus", 64'({in_ready, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size}), 64'd0);
      chk("rst_run_ctl", 64'({start_port, res_valid, res_cycles, res_status}), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      w.addr  = 14'h0000;
      w.wdata = 16'h0066;
      wr_q.push_back(w);
      send_tok(2'd1, 32'h0000_0066);
      wait_wr_drain();
      do_run(4, 32'd5, 2'd0, 0);

      repeat (3) @(negedge clock);
      chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
      chk("res_q_empty", 64'(res_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
